// File: rtl/conv_window_feeder.sv
// Sequencer that streams every sliding-window (pixel, tap) pair from local image/filter storage into a conv layer, then pulses ReadEn.
// Latency: first pair is registered on the edge that samples Go; Done follows OUT_NUM*K + 1 + READ_CYCLES edges later.
// Backpressure: none; the downstream layer must accept one pair per cycle, and writes/Go are ignored while a run is active.
module conv_window_feeder #(
    parameter int IMG_LEN     = 7,
    parameter int K           = 3,
    parameter int READ_CYCLES = 5,
    localparam int OUT_NUM    = IMG_LEN - K + 1,
    localparam int AW         = (IMG_LEN > 1) ? $clog2(IMG_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          WrEn,
    input  logic          WrSel,
    input  logic [AW-1:0] WrAddr,
    input  logic [3:0]    WrData,
    input  logic          Go,
    output logic          Busy,
    output logic          Done,
    output logic          Start,
    output logic [3:0]    Image,
    output logic [3:0]    Filter,
    output logic          ReadEn
);

    localparam int TW = (K > 1) ? $clog2(K) : 1;
    localparam int WW = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
    localparam int RW = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        GAP    = 3'd2,
        READ   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state;
    logic [3:0]    img [IMG_LEN];
    logic [3:0]    flt [K];
    logic [WW-1:0] win;
    logic [TW-1:0] tap;
    logic [RW-1:0] rcnt;

    logic [WW-1:0] nxt_win;
    logic [TW-1:0] nxt_tap;
    logic [AW-1:0] nxt_idx;
    logic          last_pair;
    logic [3:0]    img0_fwd;
    logic [3:0]    flt0_fwd;

    // Next window/tap position, and first-pair values with same-edge write forwarding
    always_comb begin
        last_pair = (win == WW'(OUT_NUM - 1)) && (tap == TW'(K - 1));
        if (tap == TW'(K - 1)) begin
            nxt_tap = '0;
            nxt_win = win + 1'b1;
        end else begin
            nxt_tap = tap + 1'b1;
            nxt_win = win;
        end
        nxt_idx  = AW'(nxt_win) + AW'(nxt_tap);
        // A write on the Go edge must be seen by pair (0,0), which is read on that same edge
        img0_fwd = (WrEn && !WrSel && (WrAddr == '0)) ? WrData : img[0];
        flt0_fwd = (WrEn &&  WrSel && (WrAddr == '0)) ? WrData : flt[0];
    end

    // Storage writes plus the run FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            win    <= '0;
            tap    <= '0;
            rcnt   <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Start  <= 1'b0;
            Image  <= '0;
            Filter <= '0;
            ReadEn <= 1'b0;
            for (int i = 0; i < IMG_LEN; i++) img[i] <= '0;
            for (int i = 0; i < K; i++)       flt[i] <= '0;
        end else begin
            // Decoder compare doubles as the range check: addresses past the array hit no entry
            if (state == IDLE && WrEn) begin
                if (!WrSel) begin
                    for (int i = 0; i < IMG_LEN; i++)
                        if (WrAddr == AW'(i)) img[i] <= WrData;
                end else begin
                    for (int i = 0; i < K; i++)
                        if (WrAddr == AW'(i)) flt[i] <= WrData;
                end
            end

            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Go) begin
                        state  <= STREAM;
                        win    <= '0;
                        tap    <= '0;
                        Busy   <= 1'b1;
                        Start  <= 1'b1;
                        Image  <= img0_fwd;
                        Filter <= flt0_fwd;
                    end
                end
                STREAM: begin
                    if (last_pair) begin
                        state  <= GAP;
                        Start  <= 1'b0;
                        Image  <= '0;
                        Filter <= '0;
                    end else begin
                        win    <= nxt_win;
                        tap    <= nxt_tap;
                        Image  <= img[nxt_idx];
                        Filter <= flt[nxt_tap];
                    end
                end
                GAP: begin
                    state  <= READ;
                    rcnt   <= '0;
                    ReadEn <= 1'b1;
                end
                READ: begin
                    if (rcnt == RW'(READ_CYCLES - 1)) begin
                        state  <= DONE;
                        ReadEn <= 1'b0;
                        Busy   <= 1'b0;
                        Done   <= 1'b1;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    Busy   <= 1'b0;
                    Done   <= 1'b0;
                    Start  <= 1'b0;
                    Image  <= '0;
                    Filter <= '0;
                    ReadEn <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench: randomized storage contents against a queue-based per-cycle reference of the whole run.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: not applicable; bench drives the DUT open-loop.
module tb_conv_window_feeder;

    localparam int IMG_LEN     = 7;
    localparam int K           = 3;
    localparam int READ_CYCLES = 5;
    localparam int OUT_NUM     = IMG_LEN - K + 1;
    localparam int AW          = 3;
    localparam int RUN_LEN     = OUT_NUM * K + 1 + READ_CYCLES + 1 + 1;

    logic          clk;
    logic          rst_n;
    logic          WrEn;
    logic          WrSel;
    logic [AW-1:0] WrAddr;
    logic [3:0]    WrData;
    logic          Go;
    logic          Busy;
    logic          Done;
    logic          Start;
    logic [3:0]    Image;
    logic [3:0]    Filter;
    logic          ReadEn;

    int total = 0;
    int bad   = 0;

    logic [3:0]  m_img [IMG_LEN];
    logic [3:0]  m_flt [K];
    logic [11:0] exp_q [$];
    int          sums  [OUT_NUM];

    conv_window_feeder #(
        .IMG_LEN     (IMG_LEN),
        .K           (K),
        .READ_CYCLES (READ_CYCLES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .WrEn   (WrEn),
        .WrSel  (WrSel),
        .WrAddr (WrAddr),
        .WrData (WrData),
        .Go     (Go),
        .Busy   (Busy),
        .Done   (Done),
        .Start  (Start),
        .Image  (Image),
        .Filter (Filter),
        .ReadEn (ReadEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] outs();
        return {Busy, Done, Start, ReadEn, Image, Filter};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_wr(input bit sel, input int addr, input logic [3:0] dat);
        if (!sel && addr < IMG_LEN) m_img[addr] = dat;
        else if (sel && addr < K)   m_flt[addr] = dat;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < IMG_LEN; i++) m_img[i] = '0;
        for (int i = 0; i < K; i++)       m_flt[i] = '0;
    endfunction

    // Whole run as a list of per-cycle output words {Busy,Done,Start,ReadEn,Image,Filter}
    function automatic void build_seq();
        exp_q.delete();
        for (int w = 0; w < OUT_NUM; w++)
            for (int t = 0; t < K; t++)
                exp_q.push_back({4'b1010, m_img[w + t], m_flt[t]});
        exp_q.push_back(12'h800);
        for (int r = 0; r < READ_CYCLES; r++) exp_q.push_back(12'h900);
        exp_q.push_back(12'h400);
        exp_q.push_back(12'h000);
    endfunction

    task automatic wr(input bit sel, input int addr, input logic [3:0] dat);
        WrEn   = 1'b1;
        WrSel  = sel;
        WrAddr = AW'(addr);
        WrData = dat;
        step();
        WrEn = 1'b0;
        model_wr(sel, addr, dat);
    endtask

    // One full run; optional write on the Go edge, optional Go/write poke during STREAM
    task automatic run(input string tag, input bit fw_en, input bit fw_sel, input int fw_addr,
                       input logic [3:0] fw_dat, input int poke_at);
        if (fw_en) begin
            WrEn   = 1'b1;
            WrSel  = fw_sel;
            WrAddr = AW'(fw_addr);
            WrData = fw_dat;
            model_wr(fw_sel, fw_addr, fw_dat);
        end
        build_seq();
        for (int w = 0; w < OUT_NUM; w++) sums[w] = 0;
        Go = 1'b1;
        step();
        Go   = 1'b0;
        WrEn = 1'b0;
        for (int i = 0; i < RUN_LEN; i++) begin
            if (i > 0) step();
            chk(tag, 32'(outs()), 32'(exp_q[i]));
            if (Start && i < OUT_NUM * K) sums[i / K] += int'(Image) * int'(Filter);
            if (i == poke_at) begin
                Go     = 1'b1;
                WrEn   = 1'b1;
                WrSel  = 1'b0;
                WrAddr = '0;
                WrData = 4'd9;
            end else if (i == poke_at + 1) begin
                Go   = 1'b0;
                WrEn = 1'b0;
            end
        end
    endtask

    task automatic chk_nominal_sums(input string tag);
        for (int w = 0; w < OUT_NUM; w++) chk(tag, 32'(sums[w]), 32'(14 + 6 * w));
    endtask

    initial begin
        int c;
        rst_n  = 1'b0;
        WrEn   = 1'b0;
        WrSel  = 1'b0;
        WrAddr = '0;
        WrData = '0;
        Go     = 1'b0;
        model_clear();

        #12;
        chk("reset_outs", 32'(outs()), 32'h0);
        rst_n = 1'b1;
        step();
        chk("post_reset_busy", 32'(Busy), 32'h0);
        chk("post_reset_start", 32'(Start), 32'h0);

        // Nominal ramp image and filter 1,2,3
        for (int i = 0; i < IMG_LEN; i++) wr(1'b0, i, 4'(i + 1));
        for (int i = 0; i < K; i++)       wr(1'b1, i, 4'(i + 1));
        run("nominal", 1'b0, 1'b0, 0, 4'd0, -10);
        chk_nominal_sums("nominal_conv");

        // Go and image write while streaming must be ignored
        run("busy_poke", 1'b0, 1'b0, 0, 4'd0, 4);
        chk_nominal_sums("busy_poke_conv");
        run("after_poke", 1'b0, 1'b0, 0, 4'd0, -10);
        chk("after_poke_img0", 32'(sums[0]), 32'd14);

        // Out-of-range addresses must not touch storage
        wr(1'b0, 7, 4'hF);
        wr(1'b1, 3, 4'hF);
        run("oob", 1'b0, 1'b0, 0, 4'd0, -10);
        chk_nominal_sums("oob_conv");

        // Random contents, random (possibly out-of-range) writes, write on the Go edge
        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < 10; n++)
                wr(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 4'($urandom));
            run("random", 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                4'($urandom), -10);
        end

        // Reset in the middle of STREAM, at the 6th pair
        build_seq();
        Go = 1'b1;
        step();
        Go = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("pre_reset_pair6", 32'(outs()), 32'(exp_q[5]));
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", 32'(outs()), 32'h0);
        #2 rst_n = 1'b1;
        model_clear();
        step();
        chk("post_abort_idle", 32'(outs()), 32'h0);
        run("cleared", 1'b0, 1'b0, 0, 4'd0, -10);

        // Go held high: runs back to back with one idle cycle after Done
        for (int i = 0; i < IMG_LEN; i++) wr(1'b0, i, 4'($urandom));
        for (int i = 0; i < K; i++)       wr(1'b1, i, 4'($urandom));
        build_seq();
        Go = 1'b1;
        c  = 0;
        while (c < 60 || (c % RUN_LEN) != RUN_LEN - 1) begin
            step();
            chk("go_held", 32'(outs()), 32'(exp_q[c % RUN_LEN]));
            if (c == 59) Go = 1'b0;
            c++;
        end
        step();
        chk("go_held_final_idle", 32'(outs()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
